// File: rtl/vector_mem_ctrl.sv
// vector_mem_ctrl: serialises one R-lane vector load/store into byte accesses
// on a single-port, byte-wide RAM, stalling the pipeline for the duration.
module vector_mem_ctrl #(
  parameter int I     = 32,
  parameter int N     = 8,
  parameter int R     = 6,
  parameter int DEPTH = 1024
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                MemReadM,
  input  logic                MemWriteM,
  input  logic [I-1:0]        AddressM,
  input  logic [R-1:0][N-1:0] WriteDataM,
  output logic [R-1:0][N-1:0] ReadData,
  output logic                StallM,
  output logic                DoneM
);

  localparam int AW = $clog2(DEPTH);
  localparam int KW = 3;
  localparam logic [KW-1:0] LastLane = KW'(R - 1);

  typedef enum logic [2:0] {IDLE, WRITE, READ, RTAIL, DONE} state_t;

  state_t                stateReg, stateNext;
  logic [KW-1:0]         laneReg, laneNext;
  logic [AW-1:0]         baseReg, baseNext;
  logic [R-1:0][N-1:0]   wdataReg, wdataNext;
  logic [R-1:0][N-1:0]   readDataReg, readDataNext;

  logic [N-1:0]          ram [DEPTH];
  logic [N-1:0]          ramRdData;
  logic [AW-1:0]         ramAddr;
  logic                  ramWe;
  logic                  captureEn;
  logic [KW-1:0]         captureLane;

  // Only the low AW address bits select a RAM byte; the rest are ignored.
  logic unusedAddrBits;
  assign unusedAddrBits = ^AddressM[I-1:AW];

  // Lane k lives at (base + k) mod DEPTH; AW-bit addition wraps for free.
  assign ramAddr = baseReg + AW'(laneReg);

  // Control registers; reset aborts any sequence in flight.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stateReg <= IDLE;
      laneReg  <= '0;
      baseReg  <= '0;
      wdataReg <= '0;
    end else begin
      stateReg <= stateNext;
      laneReg  <= laneNext;
      baseReg  <= baseNext;
      wdataReg <= wdataNext;
    end
  end

  // Sequencer: requests are only accepted in IDLE, store has priority over load.
  always_comb begin
    stateNext   = stateReg;
    laneNext    = laneReg;
    baseNext    = baseReg;
    wdataNext   = wdataReg;
    ramWe       = 1'b0;
    captureEn   = 1'b0;
    captureLane = laneReg - KW'(1);
    case (stateReg)
      IDLE: begin
        if (MemWriteM) begin
          baseNext  = AddressM[AW-1:0];
          wdataNext = WriteDataM;
          laneNext  = '0;
          stateNext = WRITE;
        end else if (MemReadM) begin
          baseNext  = AddressM[AW-1:0];
          laneNext  = '0;
          stateNext = READ;
        end
      end
      WRITE: begin
        ramWe    = 1'b1;
        laneNext = laneReg + KW'(1);
        if (laneReg == LastLane) begin
          laneNext  = '0;
          stateNext = DONE;
        end
      end
      READ: begin
        // The byte arriving now was addressed one cycle earlier (lane k-1).
        captureEn = (laneReg != '0);
        laneNext  = laneReg + KW'(1);
        if (laneReg == LastLane) begin
          laneNext  = '0;
          stateNext = RTAIL;
        end
      end
      RTAIL: begin
        captureEn   = 1'b1;
        captureLane = LastLane;
        stateNext   = DONE;
      end
      DONE:    stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
  end

  // Byte RAM: read-first, registered read, no reset so contents survive it.
  always_ff @(posedge clk) begin
    if (ramWe) begin
      ram[ramAddr] <= wdataReg[laneReg];
    end
    ramRdData <= ram[ramAddr];
  end

  // Per-lane load capture select.
  generate
    for (genvar gi = 0; gi < R; gi++) begin : gLane
      assign readDataNext[gi] = (captureEn && (captureLane == KW'(gi))) ? ramRdData
                                                                        : readDataReg[gi];
    end
  endgenerate

  // Load vector register; only loads ever change it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      readDataReg <= '0;
    end else begin
      readDataReg <= readDataNext;
    end
  end

  assign ReadData = readDataReg;
  assign StallM   = (MemReadM | MemWriteM) & (stateReg != DONE);
  assign DoneM    = (stateReg == DONE);

endmodule
